shift_right_iter_32: RTL and testbench
======================================

// Module: shift_right_iter_32
// PURPOSE
//   Multi-cycle right shifter for the CPU datapath; executes SRL/SRA (and SRLV/SRAV) by iterating STEP bits/cycle.
//   Start/done handshake with the control unit; the ALU result mux picks data_o when done_o pulses.
//   Right-shift counterpart to the combinational left shift used for branch offsets.
// PARAMETERS
//   DATA_WIDTH   32  operand/result width
//   SHAMT_WIDTH  5   shift-amount width (log2 DATA_WIDTH)
//   STEP         1   bits shifted per SHIFT cycle; legal 1,2,4
// PORTS
//   clk_i     in   1           clock, rising edge
//   rst_i     in   1           async reset, active-low
//   start_i   in   1           request; sampled only in IDLE
//   data_i    in   DATA_WIDTH  operand, captured with start_i
//   shamt_i   in   SHAMT_WIDTH shift amount, captured with start_i
//   arith_i   in   1           1=arithmetic (sign fill), 0=logical (zero fill)
//   busy_o    out  1           high in SHIFT and DONE
//   done_o    out  1           one-cycle pulse, result valid
//   data_o    out  DATA_WIDTH  result; held stable until next accepted start
// BEHAVIOUR
//   Reset (rst_i=0, async): state=IDLE, busy_o=0, done_o=0, data_o=0, counter=0, sign flag=0.
//   FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: start_i=1 at edge t: load work reg=data_i, cnt=shamt_i, fill=arith_i&data_i[MSB].
//     shamt_i==0 -> go DONE directly; else -> SHIFT.
//   SHIFT: per cycle shift by k=min(STEP,cnt); vacated MSBs take fill bit; cnt-=k.
//     cnt reaches 0 -> DONE. Exactly ceil(N/STEP) SHIFT cycles for shamt N.
//   DONE: done_o=1 for one cycle, data_o=work reg; -> IDLE.
//   Latency: done_o high in cycle after edge t+ceil(N/STEP)+1 (N=0: t+1).
//   start_i while busy_o=1 ignored; operands not re-captured; no queueing.
//   start_i in DONE cycle ignored; earliest next accept is first IDLE cycle.
//   data_o updates only on DONE entry; otherwise holds previous result.
//   N=DATA_WIDTH-1 with fill=1 on negative operand -> all ones; fill=0 -> 1 (for MSB set) or 0.
//   Reset mid-operation: immediate abort, all outputs to reset values, no done_o.
// CONFIGURATION
//   SHIFT_ARITH_EN defined: arith_i honoured, SRA supported.
//   SHIFT_ARITH_EN undefined: arith_i ignored (port kept, unconnected internally); fill always 0.
// STRUCTURE
//   Package shift_pkg: state enum {IDLE,SHIFT,DONE}, DATA_WIDTH/SHAMT_WIDTH constants.
//   Sub-module shift_step: combinational right shift by 0..STEP with fill-bit input; one instance.
//   Top holds FSM, counter, work register, output register.
// TESTING
//   1 data_i=32'h8000_0000, shamt=4, arith=0, STEP=1 -> done_o after 5 cycles, data_o=32'h0800_0000.
//   2 same, arith=1, SHIFT_ARITH_EN defined -> data_o=32'hF800_0000; macro undefined -> 32'h0800_0000.
//   3 shamt=0, data_i=32'h1234_5678 -> done_o at t+1, data_o=32'h1234_5678, busy_o 1 cycle.
//   4 shamt=31, data_i=32'hFFFF_FFFF, arith=0, STEP=4 -> 8 SHIFT cycles, data_o=32'h0000_0001.
//   5 start_i held high through op with new data_i -> single done_o, result from first capture only.
//   6 rst_i low mid-SHIFT -> busy_o/done_o/data_o=0 same cycle; no done_o after release; next start ok.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and FSM state type for the iterative right shifter.
package shift_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned SHAMT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational right shift by 0..STEP positions; vacated MSBs take the fill bit.
module shift_step #(
    parameter int unsigned W    = 32,
    parameter int unsigned CW   = 5,
    parameter int unsigned STEP = 1
) (
    input  logic [W-1:0]  data,
    input  logic [CW-1:0] amt,
    input  logic          fill,
    output logic [W-1:0]  result
);

    localparam logic [CW-1:0] STEP_MAX = CW'(STEP);

    logic [CW-1:0]  k;
    logic [2*W-1:0] ext;

    always_comb begin
        k      = (amt > STEP_MAX) ? STEP_MAX : amt;
        ext    = {{W{fill}}, data};
        result = W'(ext >> k);
    end

endmodule

// File: rtl/shift_right_iter_32.sv
// Multi-cycle SRL/SRA unit, STEP bits per cycle, start/done handshake.
// Define SHIFT_ARITH_EN to honour arith_i (sign fill); otherwise fill is always 0.
module shift_right_iter_32 #(
    parameter int unsigned DATA_WIDTH  = shift_pkg::DATA_WIDTH,
    parameter int unsigned SHAMT_WIDTH = shift_pkg::SHAMT_WIDTH,
    parameter int unsigned STEP        = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    input  logic                   arith_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  data_o
);

    import shift_pkg::*;

`ifdef SHIFT_ARITH_EN
    localparam logic ARITH_EN = 1'b1;
`else
    localparam logic ARITH_EN = 1'b0;
`endif

    localparam logic [SHAMT_WIDTH-1:0] STEP_MAX = SHAMT_WIDTH'(STEP);

    state_t                 state, state_next;
    logic [DATA_WIDTH-1:0]  work, work_next, stepped;
    logic [SHAMT_WIDTH-1:0] cnt, cnt_next, k;
    logic                   fill, fill_next;
    logic                   load_out;

    shift_step #(
        .W    (DATA_WIDTH),
        .CW   (SHAMT_WIDTH),
        .STEP (STEP)
    ) u_step (
        .data   (work),
        .amt    (cnt),
        .fill   (fill),
        .result (stepped)
    );

    always_comb begin
        state_next = state;
        work_next  = work;
        cnt_next   = cnt;
        fill_next  = fill;
        k          = (cnt > STEP_MAX) ? STEP_MAX : cnt;
        case (state)
            IDLE: begin
                if (start_i) begin
                    work_next  = data_i;
                    cnt_next   = shamt_i;
                    fill_next  = ARITH_EN & arith_i & data_i[DATA_WIDTH-1];
                    state_next = (shamt_i == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_next = stepped;
                cnt_next  = cnt - k;
                if (cnt <= STEP_MAX) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result register captures the final work value on the edge that enters DONE,
    // so data_o is already valid during the done_o pulse.
    assign load_out = (state_next == DONE) && (state != DONE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            fill   <= 1'b0;
            data_o <= '0;
        end else begin
            state <= state_next;
            work  <= work_next;
            cnt   <= cnt_next;
            fill  <= fill_next;
            if (load_out) begin
                data_o <= work_next;
            end
        end
    end

    assign busy_o = (state == SHIFT) || (state == DONE);
    assign done_o = (state == DONE);

endmodule

// File: tb/tb_shift_right_iter_32.sv
// Directed bench: one STEP=1 and one STEP=4 shifter driven with shared operands.
module tb_shift_right_iter_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic [31:0] din = '0;
    logic [4:0]  shamt = '0;
    logic        arith = 1'b0;
    logic        busy1, done1, busy4, done4;
    logic [31:0] out1, out4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_right_iter_32 #(.STEP(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start1), .data_i(din),
        .shamt_i(shamt), .arith_i(arith), .busy_o(busy1), .done_o(done1), .data_o(out1)
    );

    shift_right_iter_32 #(.STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start4), .data_i(din),
        .shamt_i(shamt), .arith_i(arith), .busy_o(busy4), .done_o(done4), .data_o(out4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Launch one op on both units and watch 40 edges: latency, busy length, pulse count, result, hold.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] n,
                          input logic a, input logic [31:0] exp,
                          input int lat1_exp, input int lat4_exp);
        int lat1, lat4, busy1_n, busy4_n, done1_n, done4_n;
        logic [31:0] res1, res4;
        lat1 = 0; lat4 = 0; busy1_n = 0; busy4_n = 0; done1_n = 0; done4_n = 0;
        res1 = 'x; res4 = 'x;
        din = d; shamt = n; arith = a; start1 = 1'b1; start4 = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            start1 = 1'b0; start4 = 1'b0;
            din = ~d; shamt = 5'd17;
            if (busy1) busy1_n++;
            if (busy4) busy4_n++;
            if (done1) begin done1_n++; if (lat1 == 0) begin lat1 = e; res1 = out1; end end
            if (done4) begin done4_n++; if (lat4 == 0) begin lat4 = e; res4 = out4; end end
        end
        check({tag, " lat1"}, 32'(lat1), 32'(lat1_exp));
        check({tag, " lat4"}, 32'(lat4), 32'(lat4_exp));
        check({tag, " busy1"}, 32'(busy1_n), 32'(lat1_exp));
        check({tag, " busy4"}, 32'(busy4_n), 32'(lat4_exp));
        check({tag, " pulses1"}, 32'(done1_n), 32'd1);
        check({tag, " pulses4"}, 32'(done4_n), 32'd1);
        check({tag, " data1"}, res1, exp);
        check({tag, " data4"}, res4, exp);
        check({tag, " hold1"}, out1, exp);
        check({tag, " hold4"}, out4, exp);
    endtask

    initial begin
        logic [31:0] sra_neg4, sra_neg31, sra_f0;
        int done_n, lat;
`ifdef SHIFT_ARITH_EN
        sra_neg4 = 32'hF800_0000; sra_neg31 = 32'hFFFF_FFFF; sra_f0 = 32'hFFF0_F0F0;
`else
        sra_neg4 = 32'h0800_0000; sra_neg31 = 32'h0000_0001; sra_f0 = 32'h00F0_F0F0;
`endif
        #3;
        check("reset busy", {30'd0, busy1, busy4}, 32'd0);
        check("reset done", {30'd0, done1, done4}, 32'd0);
        check("reset data1", out1, 32'd0);
        check("reset data4", out4, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("srl4",  32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 5, 2);
        run_op("sra4",  32'h8000_0000, 5'd4,  1'b1, sra_neg4,      5, 2);
        run_op("zero",  32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1, 1);
        run_op("srl31", 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001, 32, 9);
        run_op("sra31", 32'h8000_0000, 5'd31, 1'b1, sra_neg31,     32, 9);
        run_op("sra8",  32'hF0F0_F0F0, 5'd8,  1'b1, sra_f0,        9, 3);
        run_op("srapos",32'h7FFF_FFFF, 5'd3,  1'b1, 32'h0FFF_FFFF, 4, 2);
        run_op("srl5",  32'h0000_0100, 5'd5,  1'b0, 32'h0000_0008, 6, 3);

        // start held high through the whole op while operands change
        din = 32'h8000_0000; shamt = 5'd4; arith = 1'b0; start1 = 1'b1;
        done_n = 0; lat = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            din = 32'hFFFF_FFFF; shamt = 5'd1;
            if (done1) begin
                done_n++;
                if (lat == 0) lat = e;
                start1 = 1'b0;
            end
        end
        start1 = 1'b0;
        check("hold pulses", 32'(done_n), 32'd1);
        check("hold lat", 32'(lat), 32'd5);
        check("hold data", out1, 32'h0800_0000);

        // asynchronous reset in the middle of SHIFT
        din = 32'h8000_0000; shamt = 5'd20; arith = 1'b0; start1 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check("pre-abort busy", {30'd0, busy1, busy4}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort busy", {30'd0, busy1, busy4}, 32'd0);
        check("abort done", {30'd0, done1, done4}, 32'd0);
        check("abort data1", out1, 32'd0);
        check("abort data4", out4, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        done_n = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (done1 || done4 || busy1 || busy4) done_n++;
        end
        check("post-abort quiet", 32'(done_n), 32'd0);
        run_op("restart", 32'hA5A5_0000, 5'd16, 1'b0, 32'h0000_A5A5, 17, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
